// File: rtl/gt_rx_deframer.sv
// gt_rx_deframer: K28.5 lane alignment, link lock and SOF/EOF frame stripping on the GT rx stream.
// Define GT_RX_DEFRAMER_STAT_EN to add saturating frame/error/loss counters.
module gt_rx_deframer #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int MAX_LEN  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_charisk_i,
  input  logic        rx_resetdone_i,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  output logic        m_sof_o,
  output logic        m_eof_o,
  output logic        m_err_o,
  output logic        lock_o,
  output logic        swap_o
`ifdef GT_RX_DEFRAMER_STAT_EN
  ,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] err_cnt_o,
  output logic [15:0] loss_cnt_o
`endif
);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int IW = $clog2(LOSS_CNT + 1);
  localparam logic [HW-1:0] HLAST = HW'(LOCK_CNT - 1);
  localparam logic [IW-1:0] ILAST = IW'(LOSS_CNT - 1);
  typedef enum logic [1:0] {HUNT, IDLE, DATA, DROP} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [15:0] hd_q, hd_d, len_q, len_d, m_data_q, m_data_d;
  logic [7:0] prev_q, prev_d;
  logic prevk_q, prevk_d, swap_q, swap_d, hv_q, hv_d, lock_q, lock_d;
  logic m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d, m_err_q, m_err_d, emit;
  logic [15:0] w;
  logic [1:0] k;
  logic is_idle, is_sof, is_eof, is_data, invalid, loss, full, raw_idle, raw_shift;
  // Swapped alignment pairs this word's low byte with last word's high byte
  assign w = swap_q ? {rx_data_i[7:0], prev_q} : rx_data_i;
  assign k = swap_q ? {rx_charisk_i[0], prevk_q} : rx_charisk_i;
  assign is_idle = k == 2'b01 && w == 16'h50BC;
  assign is_sof = k == 2'b01 && w == 16'h50FB;
  assign is_eof = k == 2'b01 && w == 16'h50FD;
  assign is_data = k == 2'b00;
  assign invalid = !(is_idle || is_sof || is_eof || is_data);
  assign loss = state_q != HUNT && invalid && icnt_q == ILAST;
  assign full = len_q == 16'(MAX_LEN);
  assign raw_idle = rx_data_i == 16'h50BC && rx_charisk_i == 2'b01;
  assign raw_shift = rx_data_i[15:8] == 8'hBC && rx_charisk_i == 2'b10;
  assign prev_d = rx_resetdone_i ? rx_data_i[15:8] : '0;
  assign prevk_d = rx_resetdone_i && rx_charisk_i[1];
  assign lock_d = state_d != HUNT;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HUNT;
      hcnt_q <= '0;
      icnt_q <= '0;
      hd_q <= '0;
      len_q <= '0;
      prev_q <= '0;
      prevk_q <= 1'b0;
      swap_q <= 1'b0;
      hv_q <= 1'b0;
      lock_q <= 1'b0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
      m_sof_q <= 1'b0;
      m_eof_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      icnt_q <= icnt_d;
      hd_q <= hd_d;
      len_q <= len_d;
      prev_q <= prev_d;
      prevk_q <= prevk_d;
      swap_q <= swap_d;
      hv_q <= hv_d;
      lock_q <= lock_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
      m_sof_q <= m_sof_d;
      m_eof_q <= m_eof_d;
      m_err_q <= m_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    icnt_d = '0;
    swap_d = swap_q;
    hv_d = hv_q;
    hd_d = hd_q;
    len_d = len_q;
    if (state_q == HUNT) begin
      swap_d = raw_idle ? 1'b0 : raw_shift ? 1'b1 : swap_q;
      hcnt_d = is_idle ? hcnt_q + HW'(1) : '0;
      if (is_idle && hcnt_q == HLAST) begin
        state_d = IDLE;
        hcnt_d = '0;
      end
    end else if (loss) begin
      state_d = HUNT;
      hv_d = 1'b0;
      len_d = '0;
    end else begin
      icnt_d = invalid ? icnt_q + IW'(1) : '0;
      case (state_q)
        IDLE: if (is_sof) begin
          state_d = DATA;
          len_d = '0;
        end
        DATA: if (is_data && !full) begin
          hd_d = w;
          hv_d = 1'b1;
          len_d = len_q + 16'd1;
        end else if (!invalid) begin
          state_d = is_sof ? DATA : is_data ? DROP : IDLE;
          hv_d = 1'b0;
          len_d = '0;
        end
        DROP: if (is_sof) begin
          state_d = DATA;
          len_d = '0;
        end else if (is_eof || is_idle) state_d = IDLE;
        default: ;
      endcase
    end
    if (!rx_resetdone_i) begin
      state_d = HUNT;
      hcnt_d = '0;
      icnt_d = '0;
      swap_d = 1'b0;
      hv_d = 1'b0;
      hd_d = '0;
      len_d = '0;
    end
  end
  // Any valid symbol in DATA releases the held word; only a further DATA word below MAX_LEN leaves it untagged
  always_comb begin
    emit = rx_resetdone_i && state_q == DATA && !invalid;
    m_valid_d = emit && hv_q;
    m_sof_d = m_valid_d && len_q == 16'd1;
    m_eof_d = m_valid_d && !(is_data && !full);
    m_err_d = rx_resetdone_i && state_q == DATA &&
              (loss ? hv_q : !invalid && (is_eof ? !hv_q : (!is_data || full)));
    m_data_d = rx_resetdone_i ? hd_q : '0;
  end
  assign m_data_o = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_sof_o = m_sof_q;
  assign m_eof_o = m_eof_q;
  assign m_err_o = m_err_q;
  assign lock_o = lock_q;
  assign swap_o = swap_q;
`ifdef GT_RX_DEFRAMER_STAT_EN
  logic [31:0] frame_q, errc_q;
  logic [15:0] lossc_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_q <= '0;
      errc_q <= '0;
      lossc_q <= '0;
    end else if (rx_resetdone_i) begin
      if (m_eof_d && !m_err_d && ~&frame_q) frame_q <= frame_q + 32'd1;
      if (m_err_d && ~&errc_q) errc_q <= errc_q + 32'd1;
      if (loss && ~&lossc_q) lossc_q <= lossc_q + 16'd1;
    end
  end
  assign frame_cnt_o = frame_q;
  assign err_cnt_o = errc_q;
  assign loss_cnt_o = lossc_q;
`endif
endmodule

// File: tb/tb_gt_rx_deframer.sv
// tb_gt_rx_deframer: directed lock/frame/abort/loss/reset sequence against gt_rx_deframer (MAX_LEN = 4).
module tb_gt_rx_deframer;
  localparam logic [15:0] IDL = 16'h50BC, SOF = 16'h50FB, EOF = 16'h50FD;
  logic clk = 1'b0, rst_n = 1'b0, rdone = 1'b1;
  logic [15:0] rx_data = '0, m_data;
  logic [1:0] rx_k = '0;
  logic m_valid, m_sof, m_eof, m_err, lock, swap;
  int checks = 0, failures = 0, bare = 0;
  logic [18:0] q[$];
  logic [15:0] pa = IDL;
  logic [1:0] pk = 2'b01;

  gt_rx_deframer #(.LOCK_CNT(16), .LOSS_CNT(4), .MAX_LEN(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_data_i(rx_data), .rx_charisk_i(rx_k),
    .rx_resetdone_i(rdone), .m_data_o(m_data), .m_valid_o(m_valid), .m_sof_o(m_sof),
    .m_eof_o(m_eof), .m_err_o(m_err), .lock_o(lock), .swap_o(swap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] kk);
    rx_data = d;
    rx_k = kk;
    @(posedge clk);
    #1;
    if (m_valid) q.push_back({m_sof, m_eof, m_err, m_data});
    if (m_err && !m_valid) bare++;
  endtask

  // Raw stream whose aligned words sit one byte lane off: high byte of word n-1 + low byte of word n
  task automatic send_sh(input logic [15:0] a, input logic [1:0] ak);
    send({a[7:0], pa[15:8]}, {ak[0], pk[1]});
    pa = a;
    pk = ak;
  endtask

  task automatic idles(input int n, input bit sh);
    repeat (n) if (sh) send_sh(IDL, 2'b01); else send(IDL, 2'b01);
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [15:0] d,
                       input logic s, input logic e, input logic r);
    chk(tag, idx < q.size() ? 32'(q[idx]) : 32'hFFFF_FFFF, 32'({s, e, r, d}));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({m_valid, m_sof, m_eof, m_err, lock, swap, m_data}), 0);
    rst_n = 1'b1;
    idles(15, 0);
    chk("lock_after_15", 32'(lock), 0);
    idles(1, 0);
    chk("lock_after_16", 32'(lock), 1);
    chk("swap_normal", 32'(swap), 0);
    q.delete();
    bare = 0;
    send(SOF, 2'b01);
    send(16'h1111, 2'b00);
    chk("lat_held", 32'(m_valid), 0);
    send(16'h2222, 2'b00);
    chk("lat_out", 32'({m_valid, m_sof, m_data}), 32'({1'b1, 1'b1, 16'h1111}));
    send(16'h3333, 2'b00);
    send(EOF, 2'b01);
    idles(2, 0);
    chk("f1_size", q.size(), 3);
    chk_q("f1_w0", 0, 16'h1111, 1, 0, 0);
    chk_q("f1_w1", 1, 16'h2222, 0, 0, 0);
    chk_q("f1_w2", 2, 16'h3333, 0, 1, 0);
    chk("f1_err", bare, 0);
    q.delete();
    send(SOF, 2'b01);
    send(16'hAAAA, 2'b00);
    send(EOF, 2'b01);
    idles(2, 0);
    chk("one_size", q.size(), 1);
    chk_q("one_w0", 0, 16'hAAAA, 1, 1, 0);
    q.delete();
    send(SOF, 2'b01);
    send(EOF, 2'b01);
    idles(2, 0);
    chk("empty_size", q.size(), 0);
    chk("empty_err", bare, 1);
    q.delete();
    bare = 0;
    send(SOF, 2'b01);
    for (int i = 1; i <= 6; i++) send(16'(i), 2'b00);
    send(EOF, 2'b01);
    idles(2, 0);
    send(SOF, 2'b01);
    send(16'h5555, 2'b00);
    send(16'h6666, 2'b00);
    send(EOF, 2'b01);
    idles(2, 0);
    chk("max_size", q.size(), 6);
    chk_q("max_w1", 0, 16'h0001, 1, 0, 0);
    chk_q("max_w2", 1, 16'h0002, 0, 0, 0);
    chk_q("max_w3", 2, 16'h0003, 0, 0, 0);
    chk_q("max_w4", 3, 16'h0004, 0, 1, 1);
    chk_q("next_w0", 4, 16'h5555, 1, 0, 0);
    chk_q("next_w1", 5, 16'h6666, 0, 1, 0);
    chk("max_bare", bare, 0);
    q.delete();
    send(SOF, 2'b01);
    send(16'h7777, 2'b00);
    send(16'h8888, 2'b00);
    repeat (3) send(16'hFFFF, 2'b11);
    chk("loss_3_locked", 32'(lock), 1);
    send(16'hFFFF, 2'b11);
    chk("loss_4", 32'({lock, m_err, m_valid}), 32'(3'b010));
    chk("loss_size", q.size(), 1);
    chk_q("loss_w0", 0, 16'h7777, 1, 0, 0);
    chk("loss_bare", bare, 1);
    q.delete();
    bare = 0;
    pa = IDL;
    pk = 2'b01;
    idles(16, 1);
    chk("sh_lock_16", 32'(lock), 0);
    idles(1, 1);
    chk("sh_lock_17", 32'({lock, swap}), 32'(2'b11));
    send_sh(SOF, 2'b01);
    send_sh(16'h1111, 2'b00);
    send_sh(16'h2222, 2'b00);
    send_sh(16'h3333, 2'b00);
    send_sh(EOF, 2'b01);
    idles(3, 1);
    chk("sh_size", q.size(), 3);
    chk_q("sh_w0", 0, 16'h1111, 1, 0, 0);
    chk_q("sh_w1", 1, 16'h2222, 0, 0, 0);
    chk_q("sh_w2", 2, 16'h3333, 0, 1, 0);
    chk("sh_bare", bare, 0);
    send_sh(SOF, 2'b01);
    send_sh(16'h1234, 2'b00);
    send_sh(16'h5678, 2'b00);
    send_sh(16'h9ABC, 2'b00);
    chk("pre_arst", 32'({m_valid, m_sof, m_data}), 32'({1'b1, 1'b1, 16'h1234}));
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({m_valid, m_sof, m_eof, m_err, lock, swap, m_data}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idles(15, 0);
    chk("arst_relock_15", 32'(lock), 0);
    idles(1, 0);
    chk("arst_relock_16", 32'(lock), 1);
    send(SOF, 2'b01);
    send(16'h9999, 2'b00);
    send(16'hAAAB, 2'b00);
    chk("pre_sclr", 32'({m_valid, m_data}), 32'({1'b1, 16'h9999}));
    rdone = 1'b0;
    send(16'hBBBB, 2'b00);
    chk("sclr_outputs", 32'({m_valid, m_sof, m_eof, m_err, lock, swap, m_data}), 0);
    rdone = 1'b1;
    q.delete();
    bare = 0;
    idles(15, 0);
    chk("sclr_relock_15", 32'(lock), 0);
    idles(1, 0);
    chk("sclr_relock_16", 32'(lock), 1);
    send(SOF, 2'b01);
    send(16'hBEEF, 2'b00);
    send(EOF, 2'b01);
    idles(2, 0);
    chk("post_size", q.size(), 1);
    chk_q("post_w0", 0, 16'hBEEF, 1, 1, 0);
    chk("post_bare", bare, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gt_rx_deframer.md
Name: gt_rx_deframer

Overview:
- Receive-side consumer of the 16-bit/2-lane 8b/10b parallel stream delivered by the GTX (rxdata/rxcharisk on rxusrclk2).
- Recovers byte-lane alignment from K28.5 idle commas, declares link lock, and strips SOF/EOF-delimited frames into a payload word stream with start/end/error tags.
- It is the receive-side counterpart of the transmit framer that drives txdata/txcharisk; no backpressure, since the stream runs at line rate.

Parameters:
- LOCK_CNT, 16, consecutive aligned IDLE words required to enter lock.
- LOSS_CNT, 4, consecutive invalid words while locked that force return to HUNT.
- MAX_LEN, 1024, maximum payload words per frame; range 2..65535.

Ports:
- clk_i  in  1  rxusrclk2 domain clock.
- rst_n_i  in  1  asynchronous active-low reset.
- rx_data_i  in  16  GT rxdata; lane0 = [7:0], lane1 = [15:8].
- rx_charisk_i  in  2  GT rxcharisk, per lane.
- rx_resetdone_i  in  1  GT rx reset done; low acts as a synchronous clear.
- m_data_o  out  16  payload word.
- m_valid_o  out  1  payload word valid.
- m_sof_o  out  1  first word of frame (qualified by m_valid_o).
- m_eof_o  out  1  last word of frame (qualified by m_valid_o).
- m_err_o  out  1  frame aborted; may pulse with or without m_valid_o.
- lock_o  out  1  alignment lock.
- swap_o  out  1  lane-swap alignment in use.

Behaviour:
- Aligned-word symbols (aligned word W, aligned K):
  - IDLE = 16'h50BC, K = 2'b01.
  - SOF = 16'h50FB, K = 01.
  - EOF = 16'h50FD, K = 01.
  - DATA = any W with K = 00.
  - Every other combination is INVALID.
- Alignment:
  - prev = rx_data_i/charisk registered by one cycle.
  - swap = 0: W = rx_data_i.
  - swap = 1: W = {rx_data_i[7:0], prev[15:8]}, with K formed the same way.
  - swap is updated only in HUNT. Raw word == IDLE sets swap = 0. Raw [15:8] == 8'hBC with charisk == 2'b10 sets swap = 1.
- States: HUNT, IDLE, DATA, DROP.
- HUNT:
  - Count consecutive aligned IDLE words; any non-IDLE word clears the counter.
  - Count reaching LOCK_CNT -> IDLE, lock_o = 1.
- Lock maintenance (IDLE, DATA, DROP):
  - INVALID words are counted consecutively; any valid symbol clears the count.
  - Count reaching LOSS_CNT -> HUNT, lock_o = 0.
  - If in DATA with a held word, emit the abort (m_err_o pulse, no m_valid_o) and discard the held word.
- IDLE state: SOF -> DATA with length = 0. DATA and EOF words are ignored.
- DATA state (one-word hold register, so the last word can be tagged EOF):
  - DATA word arrives: the previously held word (if any) is emitted; m_sof_o is set if it is frame word 0. The new word is then held and length is incremented.
  - EOF with a held word: emit the held word with m_eof_o = 1 (and m_sof_o too for a 1-word frame) -> IDLE.
  - EOF with no held word (empty frame): m_err_o pulse, no m_valid_o -> IDLE.
  - IDLE symbol (abort): emit the held word with m_eof_o = 1 and m_err_o = 1, or a bare m_err_o if nothing is held -> IDLE.
  - SOF (abort and restart): same abort emission, restart with length = 0, stay in DATA.
  - DATA word when length == MAX_LEN: abort emission -> DROP.
- DROP: wait for EOF or IDLE -> IDLE; SOF -> DATA with a new frame.
- Output latency: aligned word to m_data_o is 2 clk_i cycles for a non-final word (hold stage plus output register), +1 with swap = 1.
- All outputs are registered.
- Reset (async) and rx_resetdone_i = 0 (sync) produce the same state:
  - state = HUNT; all counters, prev, swap and the hold register cleared.
  - Every output = 0.
  - A reset mid-frame emits nothing.

Optional Feature:
- Macro: GT_RX_DEFRAMER_STAT_EN.
- When defined, adds three ports:
  - frame_cnt_o out 32: increments on each m_eof_o with m_err_o = 0.
  - err_cnt_o out 32: increments on each m_err_o pulse.
  - loss_cnt_o out 16: increments on each lock loss.
- All three counters saturate at max, reset to 0, and do not clear on rx_resetdone_i.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 16 x 16'h50BC/01, then SOF, 16'h1111, 16'h2222, 16'h3333, EOF -> lock_o = 1 after the 16th idle.
  - Outputs: 1111 (sof), 2222, 3333 (eof); m_err_o = 0.
- Same frame with lane-shifted raw stream (raw 16'hBC50/2'b10 idles, payload bytes split across words) -> swap_o = 1; identical payload/tags to the previous scenario.
- Locked; SOF, 16'hAAAA, EOF -> single output 16'hAAAA with sof = eof = 1. Then SOF, EOF -> bare m_err_o pulse, no m_valid_o.
- MAX_LEN = 4; SOF + 6 data words + EOF -> words 1–3 normal, word 4 with eof = err = 1, remaining words dropped. Next SOF frame is received normally.
- Locked, mid-frame, 4 words of 16'hFFFF/K = 11 -> m_err_o pulse, lock_o = 0, state HUNT. With STAT_EN, loss_cnt_o = 1 and err_cnt_o = 1.
- rst_n_i asserted mid-frame and also rx_resetdone_i = 0 mid-frame -> all outputs 0 immediately (async) or next clock (sync). Relock requires 16 idles.
